// File: rtl/pipma_lsu_pkg.sv
// pipma_lsu_pkg: shared op codes, FSM states and access-size encodings for the MA stage
package pipma_lsu_pkg;
  localparam int OP_LB  = 1;
  localparam int OP_LH  = 2;
  localparam int OP_LW  = 3;
  localparam int OP_LBU = 4;
  localparam int OP_LHU = 5;
  localparam int OP_SB  = 6;
  localparam int OP_SH  = 7;
  localparam int OP_SW  = 8;
  typedef enum logic {IDLE, REQ} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, misalignment check and load extraction/extension
module lsu_align
  import pipma_lsu_pkg::*;
#(
  parameter int OP_W = 10
) (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      off,
  input  logic [31:0]     sdata,
  output logic [1:0]      size,
  output logic            uns,
  output logic [3:0]      be,
  output logic [31:0]     wdata,
  output logic            misalign,
  input  logic [1:0]      rsize,
  input  logic            runs,
  input  logic [1:0]      roff,
  input  logic [31:0]     rdata,
  output logic [31:0]     ldata
);
  logic is_b, is_h;
  logic [7:0] b;
  logic [15:0] h;
  assign is_b = op == OP_W'(OP_LB) || op == OP_W'(OP_LBU) || op == OP_W'(OP_SB);
  assign is_h = op == OP_W'(OP_LH) || op == OP_W'(OP_LHU) || op == OP_W'(OP_SH);
  assign uns = op == OP_W'(OP_LBU) || op == OP_W'(OP_LHU);
  // Unrecognised ops fall through to a full word access.
  assign size = is_b ? SZ_B : is_h ? SZ_H : SZ_W;
  assign be = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
  assign wdata = is_b ? {4{sdata[7:0]}} : is_h ? {2{sdata[15:0]}} : sdata;
  assign misalign = (is_h & off[0]) | (!is_b & !is_h & |off);
  assign b = rdata[{roff, 3'b000} +: 8];
  assign h = roff[1] ? rdata[31:16] : rdata[15:0];
  assign ldata = rsize == SZ_B ? {{24{b[7] & !runs}}, b} :
                 rsize == SZ_H ? {{16{h[15] & !runs}}, h} : rdata;
endmodule

// File: rtl/pipma_lsu.sv
// pipma_lsu: memory-access stage with req/ack load/store unit and wait-state timeout
module pipma_lsu
  import pipma_lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OP_W     = 10,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iValid,
  input  logic              iFlush,
  input  logic [OP_W-1:0]   iDecodedOP,
  input  logic              iMEM,
  input  logic              iRW,
  input  logic [4:0]        iDregADDR,
  input  logic [31:0]       iDregDATA,
  input  logic [31:0]       iStoreDATA,
  output logic              oStallMA,
  output logic              oValid,
  output logic [4:0]        oDregADDR,
  output logic [31:0]       oDregDATA,
  output logic              oMisalign,
  output logic              oBusErr,
  output logic [ADDR_W-1:0] oBadADDR,
  output logic              oDmemREQ,
  output logic              oDmemWE,
  output logic [ADDR_W-1:0] oDmemADDR,
  output logic [3:0]        oDmemBE,
  output logic [31:0]       oDmemWDATA,
  input  logic              iDmemACK,
  input  logic [31:0]       iDmemRDATA
);
  // Timeout fires in the REQ cycle whose count of prior unacked cycles is WAIT_MAX-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX > 0 ? WAIT_MAX - 1 : 0);
  state_e state, state_d;
  logic [CNT_W-1:0] cnt;
  logic [4:0] rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0] be_q;
  logic [31:0] wdata_q;
  logic [1:0] size_q;
  logic we_q, uns_q, flush_q;
  logic [1:0] size;
  logic uns, mis;
  logic [3:0] be;
  logic [31:0] wdata, ldata;
  logic go, start, pass, mis_ev, ack, timeout, drop;
  lsu_align #(.OP_W(OP_W)) u_align (
    .op(iDecodedOP),
    .off(iDregDATA[1:0]),
    .sdata(iStoreDATA),
    .size(size),
    .uns(uns),
    .be(be),
    .wdata(wdata),
    .misalign(mis),
    .rsize(size_q),
    .runs(uns_q),
    .roff(addr_q[1:0]),
    .rdata(iDmemRDATA),
    .ldata(ldata)
  );
  assign go = iValid & !iFlush;
  assign drop = flush_q | iFlush;
  assign oStallMA = state == REQ ? !ack & !timeout : start;
  assign oDmemREQ = state == REQ;
  assign oDmemWE = we_q;
  assign oDmemADDR = {addr_q[ADDR_W-1:2], 2'b00};
  assign oDmemBE = be_q;
  assign oDmemWDATA = wdata_q;
  // Next-state and per-cycle event decode; ACK takes priority over timeout.
  always_comb begin
    pass = 1'b0;
    start = 1'b0;
    mis_ev = 1'b0;
    ack = 1'b0;
    timeout = 1'b0;
    if (state == IDLE) begin
      pass = go & !iMEM;
      start = go & iMEM & !mis;
      mis_ev = go & iMEM & mis;
    end else begin
      ack = iDmemACK;
      timeout = WAIT_MAX > 0 && !iDmemACK && cnt == LAST;
    end
    state_d = state == IDLE ? (start ? REQ : IDLE) : (ack | timeout ? IDLE : REQ);
  end
  // State register; reset withdraws REQ immediately.
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) state <= IDLE;
    else state <= state_d;
  // Capture the transaction at issue and hold it stable for the bus; latch flushes seen during REQ.
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      cnt <= '0;
      rd_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      cnt <= state == REQ && !iDmemACK ? cnt + 1'b1 : '0;
      if (start) begin
        rd_q <= iDregADDR;
        addr_q <= iDregDATA[ADDR_W-1:0];
        be_q <= be;
        wdata_q <= wdata;
        size_q <= size;
        we_q <= !iRW;
        uns_q <= uns;
        flush_q <= 1'b0;
      end else if (state == REQ && iFlush) flush_q <= 1'b1;
    end
  // Writeback registers and exception pulses; stores complete with rd=0 so nothing is written.
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      oValid <= 1'b0;
      oDregADDR <= '0;
      oDregDATA <= '0;
      oMisalign <= 1'b0;
      oBusErr <= 1'b0;
      oBadADDR <= '0;
    end else begin
      oValid <= pass | (ack & !drop);
      oMisalign <= mis_ev;
      oBusErr <= timeout;
      if (pass) begin
        oDregADDR <= iDregADDR;
        oDregDATA <= iDregDATA;
      end else if (ack & !drop) begin
        oDregADDR <= we_q ? 5'd0 : rd_q;
        oDregDATA <= we_q ? oDregDATA : ldata;
      end
      if (mis_ev) oBadADDR <= iDregDATA[ADDR_W-1:0];
      else if (timeout) oBadADDR <= addr_q;
    end
endmodule

// File: tb/tb_pipma_lsu.sv
// tb_pipma_lsu: directed vectors for the MA stage load/store unit
module tb_pipma_lsu;
  import pipma_lsu_pkg::*;
  localparam int OP_W = 10;
  logic iCLK, iRST, iValid, iFlush, iMEM, iRW, iDmemACK;
  logic [OP_W-1:0] iDecodedOP;
  logic [4:0] iDregADDR, oDregADDR;
  logic [31:0] iDregDATA, iStoreDATA, oDregDATA, oDmemWDATA, iDmemRDATA, oBadADDR, oDmemADDR;
  logic oStallMA, oValid, oMisalign, oBusErr, oDmemREQ, oDmemWE;
  logic [3:0] oDmemBE;
  int vectors = 0;
  int errors = 0;
  pipma_lsu #(.ADDR_W(32), .OP_W(OP_W), .WAIT_MAX(4), .CNT_W(5)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iFlush(iFlush),
    .iDecodedOP(iDecodedOP), .iMEM(iMEM), .iRW(iRW),
    .iDregADDR(iDregADDR), .iDregDATA(iDregDATA), .iStoreDATA(iStoreDATA),
    .oStallMA(oStallMA), .oValid(oValid), .oDregADDR(oDregADDR), .oDregDATA(oDregDATA),
    .oMisalign(oMisalign), .oBusErr(oBusErr), .oBadADDR(oBadADDR),
    .oDmemREQ(oDmemREQ), .oDmemWE(oDmemWE), .oDmemADDR(oDmemADDR), .oDmemBE(oDmemBE),
    .oDmemWDATA(oDmemWDATA), .iDmemACK(iDmemACK), .iDmemRDATA(iDmemRDATA)
  );
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask
  task automatic present(input int op, input logic mem, input logic rw, input logic [4:0] rd,
                         input logic [31:0] d, input logic [31:0] sd);
    iValid = 1'b1;
    iDecodedOP = OP_W'(op);
    iMEM = mem;
    iRW = rw;
    iDregADDR = rd;
    iDregDATA = d;
    iStoreDATA = sd;
  endtask
  task automatic idle;
    iValid = 1'b0;
    iMEM = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(oDmemREQ), 0);
    chk({tag, "_stall"}, 32'(oStallMA), 0);
    chk({tag, "_valid"}, 32'(oValid), 0);
    chk({tag, "_rd"}, 32'(oDregADDR), 0);
    chk({tag, "_data"}, oDregDATA, 0);
    chk({tag, "_mis"}, 32'(oMisalign), 0);
    chk({tag, "_berr"}, 32'(oBusErr), 0);
    chk({tag, "_bad"}, oBadADDR, 0);
    chk({tag, "_addr"}, oDmemADDR, 0);
    chk({tag, "_be"}, 32'(oDmemBE), 0);
    chk({tag, "_wdata"}, oDmemWDATA, 0);
    chk({tag, "_we"}, 32'(oDmemWE), 0);
  endtask
  initial begin
    iRST = 1'b1; iValid = 0; iFlush = 0; iMEM = 0; iRW = 0; iDmemACK = 0;
    iDecodedOP = '0; iDregADDR = '0; iDregDATA = '0; iStoreDATA = '0; iDmemRDATA = '0;
    #2;
    chk_zero("reset");
    tick; tick;
    iRST = 1'b0;
    // LB 0x103 with two wait states
    present(OP_LB, 1, 1, 5'd4, 32'h103, 0);
    #1 chk("lb_stall_present", 32'(oStallMA), 1);
    chk("lb_noreq_present", 32'(oDmemREQ), 0);
    tick; idle;
    #1 chk("lb_req1", 32'(oDmemREQ), 1);
    chk("lb_addr", oDmemADDR, 32'h100);
    chk("lb_be", 32'(oDmemBE), 32'h8);
    chk("lb_we", 32'(oDmemWE), 0);
    chk("lb_stall1", 32'(oStallMA), 1);
    tick;
    #1 chk("lb_req2", 32'(oDmemREQ), 1);
    chk("lb_stall2", 32'(oStallMA), 1);
    tick;
    iDmemACK = 1; iDmemRDATA = 32'h80112233;
    #1 chk("lb_req3", 32'(oDmemREQ), 1);
    chk("lb_stall_ack", 32'(oStallMA), 0);
    tick; iDmemACK = 0;
    chk("lb_valid", 32'(oValid), 1);
    chk("lb_rd", 32'(oDregADDR), 4);
    chk("lb_data", oDregDATA, 32'hFFFFFF80);
    chk("lb_req_done", 32'(oDmemREQ), 0);
    // LHU / LH 0x102 with immediate ACK
    present(OP_LHU, 1, 1, 5'd8, 32'h102, 0);
    tick; idle;
    chk("lhu_novalid_e1", 32'(oValid), 0);
    chk("lhu_be", 32'(oDmemBE), 32'hC);
    iDmemACK = 1; iDmemRDATA = 32'hBEEF1234;
    tick; iDmemACK = 0;
    chk("lhu_valid", 32'(oValid), 1);
    chk("lhu_data", oDregDATA, 32'h0000BEEF);
    present(OP_LH, 1, 1, 5'd9, 32'h102, 0);
    tick; idle;
    iDmemACK = 1;
    tick; iDmemACK = 0;
    chk("lh_valid", 32'(oValid), 1);
    chk("lh_rd", 32'(oDregADDR), 9);
    chk("lh_data", oDregDATA, 32'hFFFFBEEF);
    // SB 0x201
    present(OP_SB, 1, 0, 5'd7, 32'h201, 32'h000000A5);
    tick; idle;
    chk("sb_we", 32'(oDmemWE), 1);
    chk("sb_be", 32'(oDmemBE), 32'h2);
    chk("sb_wdata", oDmemWDATA, 32'hA5A5A5A5);
    chk("sb_addr", oDmemADDR, 32'h200);
    iDmemACK = 1;
    tick; iDmemACK = 0;
    chk("sb_valid", 32'(oValid), 1);
    chk("sb_rd", 32'(oDregADDR), 0);
    // LW 0x104 full word
    present(OP_LW, 1, 1, 5'd10, 32'h104, 0);
    tick; idle;
    chk("lw_be", 32'(oDmemBE), 32'hF);
    iDmemACK = 1; iDmemRDATA = 32'hCAFEF00D;
    tick; iDmemACK = 0;
    chk("lw_data", oDregDATA, 32'hCAFEF00D);
    // Misaligned LW 0x106 and SH 0x103
    present(OP_LW, 1, 1, 5'd3, 32'h106, 0);
    #1 chk("mis_lw_stall", 32'(oStallMA), 0);
    chk("mis_lw_req", 32'(oDmemREQ), 0);
    tick; idle;
    chk("mis_lw_pulse", 32'(oMisalign), 1);
    chk("mis_lw_bad", oBadADDR, 32'h106);
    chk("mis_lw_valid", 32'(oValid), 0);
    chk("mis_lw_req_after", 32'(oDmemREQ), 0);
    tick;
    chk("mis_lw_pulse_end", 32'(oMisalign), 0);
    present(OP_SH, 1, 0, 5'd3, 32'h103, 32'h1111);
    #1 chk("mis_sh_stall", 32'(oStallMA), 0);
    tick; idle;
    chk("mis_sh_pulse", 32'(oMisalign), 1);
    chk("mis_sh_bad", oBadADDR, 32'h103);
    chk("mis_sh_req", 32'(oDmemREQ), 0);
    tick;
    // Timeout: LW 0x40 never acked, WAIT_MAX=4
    present(OP_LW, 1, 1, 5'd3, 32'h40, 0);
    tick; idle;
    for (int i = 0; i < 3; i++) begin
      #1 chk("to_req", 32'(oDmemREQ), 1);
      chk("to_stall", 32'(oStallMA), 1);
      tick;
    end
    #1 chk("to_req4", 32'(oDmemREQ), 1);
    chk("to_stall4", 32'(oStallMA), 0);
    tick;
    chk("to_req_drop", 32'(oDmemREQ), 0);
    chk("to_berr", 32'(oBusErr), 1);
    chk("to_bad", oBadADDR, 32'h40);
    chk("to_valid", 32'(oValid), 0);
    tick;
    chk("to_berr_end", 32'(oBusErr), 0);
    // Asynchronous reset mid-REQ
    present(OP_LW, 1, 1, 5'd3, 32'h44, 0);
    tick; idle;
    #1 chk("rst_req_before", 32'(oDmemREQ), 1);
    #1 iRST = 1'b1;
    #1 chk_zero("rst_mid");
    tick;
    iRST = 1'b0;
    tick;
    // Back-to-back passthrough
    present(OP_LW, 0, 0, 5'd5, 32'h1234, 0);
    #1 chk("pass_stall", 32'(oStallMA), 0);
    tick;
    chk("pass1_valid", 32'(oValid), 1);
    chk("pass1_rd", 32'(oDregADDR), 5);
    chk("pass1_data", oDregDATA, 32'h1234);
    present(OP_LW, 0, 0, 5'd6, 32'h5678, 0);
    tick; idle;
    chk("pass2_valid", 32'(oValid), 1);
    chk("pass2_rd", 32'(oDregADDR), 6);
    chk("pass2_data", oDregDATA, 32'h5678);
    tick;
    chk("pass_idle_valid", 32'(oValid), 0);
    chk("pass_hold_data", oDregDATA, 32'h5678);
    // Flush during REQ
    present(OP_LW, 1, 1, 5'd9, 32'h80, 0);
    tick; idle;
    iFlush = 1;
    #1 chk("flush_req", 32'(oDmemREQ), 1);
    tick; iFlush = 0;
    chk("flush_req_held", 32'(oDmemREQ), 1);
    iDmemACK = 1; iDmemRDATA = 32'h99999999;
    #1 chk("flush_stall_ack", 32'(oStallMA), 0);
    tick; iDmemACK = 0;
    chk("flush_valid", 32'(oValid), 0);
    chk("flush_req_done", 32'(oDmemREQ), 0);
    chk("flush_rd_hold", 32'(oDregADDR), 6);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
